// File: rtl/vga_timing_pkg.sv
// Default VGA 640x480@60 timing constants, derived totals and sync windows,
// plus the 10-bit counter type shared by the sync generator slice.
package vga_timing_pkg;

    localparam int CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FRONT_DEF  = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BACK_DEF   = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FRONT_DEF  = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BACK_DEF   = 33;

    // Length of one full axis period (visible + porches + sync)
    function automatic cnt_t axis_total(int act, int front, int sync, int back);
        return cnt_t'(act + front + sync + back);
    endfunction

    localparam cnt_t H_TOTAL      = axis_total(H_ACTIVE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
    localparam cnt_t V_TOTAL      = axis_total(V_ACTIVE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);
    localparam cnt_t H_SYNC_START = cnt_t'(H_ACTIVE_DEF + H_FRONT_DEF);
    localparam cnt_t H_SYNC_END   = cnt_t'(H_ACTIVE_DEF + H_FRONT_DEF + H_SYNC_DEF);
    localparam cnt_t V_SYNC_START = cnt_t'(V_ACTIVE_DEF + V_FRONT_DEF);
    localparam cnt_t V_SYNC_END   = cnt_t'(V_ACTIVE_DEF + V_FRONT_DEF + V_SYNC_DEF);

endpackage

// File: rtl/vga_sync_gen_if.sv
// Video timing bundle: pixel position, active-low syncs, active window and
// frame start marker. The generator drives it (master), consumers read it.
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    cnt_t xCount;
    cnt_t yCount;
    logic hsync;
    logic vsync;
    logic active;
    logic frame_start;

    modport master (output xCount, yCount, hsync, vsync, active, frame_start);
    modport slave  (input  xCount, yCount, hsync, vsync, active, frame_start);

endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical): a wrapping 10-bit position
// counter with registered active-low sync and in-active flags that change on
// the same edge as the count they describe. 'wrap' is combinational and
// flags the step from the last position back to 0, used to enable the next
// axis.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FRONT  = 16,
    parameter int SYNC   = 96,
    parameter int BACK   = 48
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic enable,
    output cnt_t count,
    output logic sync_n,
    output logic in_active,
    output logic wrap
);

    localparam cnt_t LAST       = cnt_t'(ACTIVE + FRONT + SYNC + BACK - 1);
    localparam cnt_t ACTIVE_END = cnt_t'(ACTIVE);
    localparam cnt_t SYNC_START = cnt_t'(ACTIVE + FRONT);
    localparam cnt_t SYNC_END   = cnt_t'(ACTIVE + FRONT + SYNC);

    cnt_t count_reg;
    cnt_t count_next;
    logic sync_n_reg;
    logic in_active_reg;
    logic step;

    assign step = tick & enable;
    assign wrap = step & (count_reg == LAST);

    // Next position: advance on a step, returning to 0 after the last one
    always_comb begin
        count_next = count_reg;
        if (step) begin
            count_next = (count_reg == LAST) ? '0 : count_reg + cnt_t'(1);
        end
    end

    // Register count and decode flags from the next count so all stay aligned
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg     <= '0;
            sync_n_reg    <= 1'b1;
            in_active_reg <= 1'b1;
        end else begin
            count_reg     <= count_next;
            sync_n_reg    <= !((count_next >= SYNC_START) && (count_next < SYNC_END));
            in_active_reg <= (count_next < ACTIVE_END);
        end
    end

    assign count     = count_reg;
    assign sync_n    = sync_n_reg;
    assign in_active = in_active_reg;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: horizontal and vertical axis counters chained by the
// horizontal wrap, with registered syncs, active window and a frame start
// pulse held for one pixel period at (0,0) after every frame wrap.
// Optional macro VGA_SYNC_PIXEL_DIV_EN: pixel tick every second clk instead
// of every clk.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FRONT  = H_FRONT_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BACK   = H_BACK_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FRONT  = V_FRONT_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BACK   = V_BACK_DEF
) (
    input  logic           clk,
    input  logic           rst,
    vga_sync_gen_if.master vga
);

    logic tick;
    logic h_wrap;
    logic v_wrap;
    logic h_in_active;
    logic v_in_active;
    logic frame_start_reg;
    cnt_t h_count;
    cnt_t v_count;
    logic h_sync_n;
    logic v_sync_n;

`ifdef VGA_SYNC_PIXEL_DIV_EN
    logic div_reg;

    // Pixel clock divider: 0 after reset, tick on the cycles it reads 1
    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg <= 1'b0;
        end else begin
            div_reg <= ~div_reg;
        end
    end

    assign tick = div_reg;
`else
    assign tick = 1'b1;
`endif

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK)
    ) u_h_axis (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .enable    (1'b1),
        .count     (h_count),
        .sync_n    (h_sync_n),
        .in_active (h_in_active),
        .wrap      (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK)
    ) u_v_axis (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .enable    (h_wrap),
        .count     (v_count),
        .sync_n    (v_sync_n),
        .in_active (v_in_active),
        .wrap      (v_wrap)
    );

    // Frame start: set by the tick that wraps both axes, cleared by the next tick
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_start_reg <= 1'b0;
        end else if (tick) begin
            frame_start_reg <= h_wrap & v_wrap;
        end
    end

    assign vga.xCount      = h_count;
    assign vga.yCount      = v_count;
    assign vga.hsync       = h_sync_n;
    assign vga.vsync       = v_sync_n;
    assign vga.active      = h_in_active & v_in_active;
    assign vga.frame_start = frame_start_reg;

endmodule
